// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - single-port data memory with req/ready handshake and wait states (optional DATA_MEMORY_CTRL_PARITY_EN)
module data_memory_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  read_signal,
    input  logic                  write_signal,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  ready,
`ifdef DATA_MEMORY_CTRL_PARITY_EN
    output logic                  parity_error,
`endif
    output logic                  busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);
`ifdef DATA_MEMORY_CTRL_PARITY_EN
    localparam int WORD_W = DATA_WIDTH + 1;
`else
    localparam int WORD_W = DATA_WIDTH;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      count;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  op_rd;
    logic                  op_wr;

    logic [WORD_W-1:0]     mem [DEPTH];
    logic [WORD_W-1:0]     wr_word;
    logic [WORD_W-1:0]     rd_word;
    logic                  access_now;

    // The array access happens on the edge that ends the last BUSY cycle.
    assign access_now = (state == S_BUSY) && (count == '0);
    assign rd_word    = mem[addr_q];

`ifdef DATA_MEMORY_CTRL_PARITY_EN
    // Stored parity bit makes the whole word even.
    assign wr_word = {^data_q, data_q};
`else
    assign wr_word = data_q;
`endif

    // Array write port; not reset, and gated off whenever the FSM has been reset.
    always_ff @(posedge clk) begin
        if (access_now && op_wr) begin
            mem[addr_q] <= wr_word;
        end
    end

    // Handshake FSM: latch request in IDLE, count wait states, access, one-cycle ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            count  <= '0;
            addr_q <= '0;
            data_q <= '0;
            op_rd  <= 1'b0;
            op_wr  <= 1'b0;
            out    <= '0;
            ready  <= 1'b0;
            busy   <= 1'b0;
`ifdef DATA_MEMORY_CTRL_PARITY_EN
            parity_error <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    ready <= 1'b0;
                    if (read_signal || write_signal) begin
                        addr_q <= address;
                        data_q <= in;
                        op_rd  <= read_signal;
                        op_wr  <= write_signal;
                        count  <= CNT_LOAD;
                        state  <= S_BUSY;
                        busy   <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end else begin
                        // Read sees the pre-write word because the array updates on this same edge.
                        if (op_rd) begin
                            out <= rd_word[DATA_WIDTH-1:0];
`ifdef DATA_MEMORY_CTRL_PARITY_EN
                            parity_error <= ^rd_word;
`endif
                        end
                        state <= S_DONE;
                        ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - randomized self-checking bench for data_memory_ctrl at wait states 0, 2 and 3
module tb_data_memory_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] addr    [3];
    logic [7:0] din     [3];
    logic [7:0] dout    [3];
    logic       rd_req  [3];
    logic       wr_req  [3];
    logic       rdy     [3];
    logic       bsy     [3];
`ifdef DATA_MEMORY_CTRL_PARITY_EN
    logic       perr    [3];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ref_mem [3][256];
    logic [7:0] ref_out [3];

    data_memory_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .address(addr[0]), .in(din[0]),
        .read_signal(rd_req[0]), .write_signal(wr_req[0]),
        .out(dout[0]), .ready(rdy[0]),
`ifdef DATA_MEMORY_CTRL_PARITY_EN
        .parity_error(perr[0]),
`endif
        .busy(bsy[0])
    );

    data_memory_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst), .address(addr[1]), .in(din[1]),
        .read_signal(rd_req[1]), .write_signal(wr_req[1]),
        .out(dout[1]), .ready(rdy[1]),
`ifdef DATA_MEMORY_CTRL_PARITY_EN
        .parity_error(perr[1]),
`endif
        .busy(bsy[1])
    );

    data_memory_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .address(addr[2]), .in(din[2]),
        .read_signal(rd_req[2]), .write_signal(wr_req[2]),
        .out(dout[2]), .ready(rdy[2]),
`ifdef DATA_MEMORY_CTRL_PARITY_EN
        .parity_error(perr[2]),
`endif
        .busy(bsy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transaction on DUT k; entered and left at a falling edge.
    // Expected timing: busy for cycles 1..ws+2 after acceptance, ready only in cycle ws+2.
    task automatic access(input int k, input logic [7:0] a, input logic [7:0] d,
                          input logic rd, input logic wr, input bit hold);
        int         ws;
        logic [7:0] exp_out;
        ws         = ws_of(k);
        addr[k]    = a;
        din[k]     = d;
        rd_req[k]  = rd;
        wr_req[k]  = wr;
        exp_out    = rd ? ref_mem[k][a] : ref_out[k];
        if (wr) ref_mem[k][a] = d;
        ref_out[k] = exp_out;
        for (int c = 1; c <= ws + 3; c++) begin
            @(negedge clk);
            check_eq($sformatf("busy k%0d c%0d", k, c), {31'b0, bsy[k]}, {31'b0, (c <= ws + 2)});
            check_eq($sformatf("ready k%0d c%0d", k, c), {31'b0, rdy[k]}, {31'b0, (c == ws + 2)});
            if (c == ws + 2) begin
                check_eq($sformatf("out k%0d a%0h", k, a), {24'b0, dout[k]}, {24'b0, exp_out});
`ifdef DATA_MEMORY_CTRL_PARITY_EN
                check_eq($sformatf("perr k%0d", k), {31'b0, perr[k]}, 32'd0);
`endif
            end
            if (c == 1 && !hold) begin
                rd_req[k] = 1'b0;
                wr_req[k] = 1'b0;
                addr[k]   = a ^ 8'h30;
                din[k]    = 8'($urandom);
            end
        end
    endtask

    task automatic idle_all();
        for (int k = 0; k < 3; k++) begin
            rd_req[k] = 1'b0;
            wr_req[k] = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            addr[k] = '0; din[k] = '0; rd_req[k] = 1'b0; wr_req[k] = 1'b0; ref_out[k] = 8'h00;
        end

        // Asynchronous reset before the first clock edge.
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("rst out k%0d", k), {24'b0, dout[k]}, 32'd0);
            check_eq($sformatf("rst ready k%0d", k), {31'b0, rdy[k]}, 32'd0);
            check_eq($sformatf("rst busy k%0d", k), {31'b0, bsy[k]}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed write/read pairs.
        access(0, 8'h10, 8'hA5, 1'b0, 1'b1, 1'b0);
        access(0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0);
        access(2, 8'h10, 8'h5A, 1'b0, 1'b1, 1'b0);
        access(2, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0);

        // Back-to-back reads with the request held continuously.
        access(0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1);
        access(0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1);
        access(2, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1);
        access(2, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1);
        idle_all();
        @(negedge clk);
        check_eq("held release ready", {31'b0, rdy[0]}, 32'd0);

        // Simultaneous read and write: read-before-write.
        for (int k = 0; k < 3; k++) begin
            access(k, 8'h33, 8'h11, 1'b0, 1'b1, 1'b0);
            access(k, 8'h33, 8'h22, 1'b1, 1'b1, 1'b0);
            access(k, 8'h33, 8'h00, 1'b1, 1'b0, 1'b0);
        end

        // Reset one cycle after acceptance aborts the write.
        access(1, 8'h40, 8'h00, 1'b0, 1'b1, 1'b0);
        addr[1] = 8'h40; din[1] = 8'hFF; wr_req[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        wr_req[1] = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("abort busy", {31'b0, bsy[1]}, 32'd0);
        check_eq("abort ready", {31'b0, rdy[1]}, 32'd0);
        for (int k = 0; k < 3; k++) ref_out[k] = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_eq($sformatf("abort ready c%0d", c), {31'b0, rdy[1]}, 32'd0);
            check_eq($sformatf("abort busy c%0d", c), {31'b0, bsy[1]}, 32'd0);
        end
        access(1, 8'h40, 8'h00, 1'b1, 1'b0, 1'b0);

        // Randomized traffic over a pre-initialised address window.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 16; i++) begin
                access(k, 8'h80 + 8'(i), 8'($urandom), 1'b0, 1'b1, 1'b0);
            end
            for (int i = 0; i < 40; i++) begin
                int         op;
                logic [7:0] ra;
                op = $urandom_range(0, 2);
                ra = 8'h80 + 8'($urandom_range(0, 15));
                access(k, ra, 8'($urandom), (op != 1), (op != 0), bit'($urandom_range(0, 1)));
            end
            idle_all();
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
